// File: rtl/coin_feeder_if.sv
// rtl/coin_feeder_if.sv - coin interface bundle between the test controller, coin feeder and vending FSM
interface coin_feeder_if #(
    parameter int AMOUNT_W = 6
);
    logic                start;
    logic [AMOUNT_W-1:0] amount;
    logic                prefer_five;
    logic                coffee;
    logic [1:0]          coins;
    logic                busy;
    logic                done;
    logic [AMOUNT_W-1:0] coffees;

    modport master (
        output start, amount, prefer_five, coffee,
        input  coins, busy, done, coffees
    );

    modport slave (
        input  start, amount, prefer_five, coffee,
        output coins, busy, done, coffees
    );
endinterface

// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - drives the 2-bit coin bus for a payment amount and counts coffee pulses
module coin_feeder #(
    parameter int AMOUNT_W   = 6,
    parameter int GAP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    coin_feeder_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]          state;
    logic [AMOUNT_W-1:0] remaining;
    logic                mode;
    logic [GW-1:0]       gap_cnt;
    logic [AMOUNT_W-1:0] coffees;

    logic                send_ten;
    logic [AMOUNT_W-1:0] rem_next;

    // Coin choice depends only on registered state so the vending FSM's
    // Mealy coffee output can never close a loop back into coins.
    assign send_ten = !mode && (remaining >= AMOUNT_W'(2));
    assign rem_next = remaining - (send_ten ? AMOUNT_W'(2) : AMOUNT_W'(1));

    assign bus.coins   = (state == S_SEND) ? (send_ten ? 2'b01 : 2'b10) : 2'b00;
    assign bus.busy    = (state == S_SEND) || (state == S_GAP);
    assign bus.done    = (state == S_DONE);
    assign bus.coffees = coffees;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            mode      <= 1'b0;
            gap_cnt   <= '0;
            coffees   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        coffees <= '0;
                        if (bus.amount != '0) begin
                            remaining <= bus.amount;
                            mode      <= bus.prefer_five;
                            state     <= S_SEND;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    remaining <= rem_next;
                    if (bus.coffee) begin
                        coffees <= coffees + AMOUNT_W'(1);
                    end
                    if (rem_next == '0) begin
                        state <= S_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
